video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 170 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Purpose: raster timing generator - pixel/line counters, blanking, adjustable syncs, RGB gating, frame strobe.
// Latency: HBLK/VBLK/HSYN/oRGB lag the counters by one pixel enable; VSYN switches on the hcnt wrap edge.
// Backpressure: none; CE_PIX gates every state update, and all flop outputs hold between enables.
module video_timing_gen #(
    parameter int H_TOTAL      = 384,
    parameter int H_ACT_START  = 16,
    parameter int H_ACT        = 256,
    parameter int H_SYNC_START = 311,
    parameter int H_SYNC_LEN   = 32,
    parameter int V_TOTAL      = 263,
    parameter int V_ACT_START  = 16,
    parameter int V_ACT        = 192,
    parameter int V_SYNC_START = 235,
    parameter int V_SYNC_LEN   = 8,
    parameter int RGB_W        = 12,
    parameter int CNT_W        = 9
) (
    input  logic             MCLK,
    input  logic             RESET,
    input  logic             CE_PIX,
    input  logic [3:0]       H_ADJ,
    input  logic [3:0]       V_ADJ,
    input  logic [RGB_W-1:0] iRGB,
    output logic [CNT_W-1:0] HPOS,
    output logic [CNT_W-1:0] VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             FRAME_STB
);

    // One spare bit for unsigned range compares, two for signed sync arithmetic.
    localparam int EW = CNT_W + 1;
    localparam int SW = CNT_W + 2;

    localparam logic signed [SW-1:0] HT_S = SW'(H_TOTAL);
    localparam logic signed [SW-1:0] VT_S = SW'(V_TOTAL);

    // Parameter sets that cannot produce a legal raster stop elaboration.
    if (H_ACT_START + H_ACT > H_TOTAL) begin : g_bad_h_act
        $error("video_timing_gen: horizontal active region exceeds H_TOTAL");
    end
    if (V_ACT_START + V_ACT > V_TOTAL) begin : g_bad_v_act
        $error("video_timing_gen: vertical active region exceeds V_TOTAL");
    end
    if (H_SYNC_LEN >= H_TOTAL || V_SYNC_LEN >= V_TOTAL) begin : g_bad_sync_len
        $error("video_timing_gen: sync length must be shorter than its total");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
        $error("video_timing_gen: totals do not fit in CNT_W bits");
    end
    if (H_SYNC_START >= H_TOTAL || V_SYNC_START >= V_TOTAL) begin : g_bad_sync_start
        $error("video_timing_gen: nominal sync start must lie inside the raster");
    end

    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  vcnt;
    logic [CNT_W-1:0]  vcnt_next;
    logic signed [3:0] h_adj;
    logic signed [3:0] v_adj;
    logic signed [3:0] v_adj_eff;
    logic              h_last;
    logic              v_last;
    logic              frame_end;
    logic              h_act;
    logic              v_act;
    logic signed [SW-1:0] hs_start;
    logic signed [SW-1:0] hs_dist;
    logic signed [SW-1:0] vs_start;
    logic signed [SW-1:0] vs_dist;
    logic              h_in_sync;
    logic              v_in_sync;

    assign h_last    = (hcnt == CNT_W'(H_TOTAL - 1));
    assign v_last    = (vcnt == CNT_W'(V_TOTAL - 1));
    assign frame_end = h_last && v_last;

    // Active-relative positions wrap naturally modulo 2^CNT_W.
    assign HPOS = hcnt - CNT_W'(H_ACT_START);
    assign VPOS = vcnt - CNT_W'(V_ACT_START);

    // Active window decode and line number the vertical counter moves to on a line wrap.
    always_comb begin
        h_act     = ({1'b0, hcnt} >= EW'(H_ACT_START)) && ({1'b0, hcnt} < EW'(H_ACT_START + H_ACT));
        v_act     = ({1'b0, vcnt} >= EW'(V_ACT_START)) && ({1'b0, vcnt} < EW'(V_ACT_START + V_ACT));
        vcnt_next = v_last ? '0 : vcnt + 1'b1;
        // The first line of a new frame already uses the offset being captured at the frame boundary.
        v_adj_eff = frame_end ? $signed(V_ADJ) : v_adj;
    end

    // Horizontal sync window: start folded into 0..H_TOTAL-1, then a modular distance test so the window may wrap through hcnt=0.
    always_comb begin
        hs_start = SW'(H_SYNC_START) + SW'(h_adj);
        if (hs_start[SW-1]) begin
            hs_start = hs_start + HT_S;
        end else if (hs_start >= HT_S) begin
            hs_start = hs_start - HT_S;
        end
        hs_dist = $signed({2'b00, hcnt}) - hs_start;
        if (hs_dist[SW-1]) begin
            hs_dist = hs_dist + HT_S;
        end
        h_in_sync = (hs_dist < SW'(H_SYNC_LEN));
    end

    // Vertical sync window, evaluated for the line about to start so VSYN edges land on the hcnt=0 boundary.
    always_comb begin
        vs_start = SW'(V_SYNC_START) + SW'(v_adj_eff);
        if (vs_start[SW-1]) begin
            vs_start = vs_start + VT_S;
        end else if (vs_start >= VT_S) begin
            vs_start = vs_start - VT_S;
        end
        vs_dist = $signed({2'b00, vcnt_next}) - vs_start;
        if (vs_dist[SW-1]) begin
            vs_dist = vs_dist + VT_S;
        end
        v_in_sync = (vs_dist < SW'(V_SYNC_LEN));
    end

    // Raster counters and per-frame capture of the sync offsets.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            hcnt  <= '0;
            vcnt  <= '0;
            h_adj <= '0;
            v_adj <= '0;
        end else if (CE_PIX) begin
            hcnt <= h_last ? '0 : hcnt + 1'b1;
            if (h_last) begin
                vcnt <= vcnt_next;
            end
            if (frame_end) begin
                h_adj <= $signed(H_ADJ);
                v_adj <= $signed(V_ADJ);
            end
        end
    end

    // Registered blanking, gated pixel and sync outputs; they change only on pixel enables.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            HBLK <= 1'b1;
            VBLK <= 1'b1;
            HSYN <= 1'b1;
            VSYN <= 1'b1;
            oRGB <= '0;
        end else if (CE_PIX) begin
            HBLK <= !h_act;
            VBLK <= !v_act;
            oRGB <= (h_act && v_act) ? iRGB : '0;
            HSYN <= !h_in_sync;
            if (h_last) begin
                VSYN <= !v_in_sync;
            end
        end
    end

    // Frame strobe lasts one MCLK even when pixel enables are sparse.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            FRAME_STB <= 1'b0;
        end else begin
            FRAME_STB <= CE_PIX && frame_end;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Purpose: self-checking bench for video_timing_gen on a reduced raster with a position-arithmetic reference model.
// Latency: expected outputs derive from the pixel-enable count since reset; checks sample 1 time unit after each MCLK edge.
// Backpressure: none; the bench drives CE_PIX patterns (constant, every 4th, random) and random sync offsets.
module tb_video_timing_gen;

    localparam int HT  = 24;
    localparam int HAS = 3;
    localparam int HA  = 14;
    localparam int HSS = 18;
    localparam int HSL = 4;
    localparam int VT  = 12;
    localparam int VAS = 2;
    localparam int VA  = 7;
    localparam int VSS = 9;
    localparam int VSL = 2;
    localparam int RW  = 12;
    localparam int CW  = 6;
    localparam int FT  = HT * VT;

    logic          MCLK = 1'b0;
    logic          RESET;
    logic          CE_PIX;
    logic [3:0]    H_ADJ;
    logic [3:0]    V_ADJ;
    logic [RW-1:0] iRGB;
    logic [CW-1:0] HPOS;
    logic [CW-1:0] VPOS;
    logic [RW-1:0] oRGB;
    logic          HBLK;
    logic          VBLK;
    logic          HSYN;
    logic          VSYN;
    logic          FRAME_STB;

    video_timing_gen #(
        .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACT(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
        .RGB_W(RW), .CNT_W(CW)
    ) dut (
        .MCLK(MCLK), .RESET(RESET), .CE_PIX(CE_PIX), .H_ADJ(H_ADJ), .V_ADJ(V_ADJ),
        .iRGB(iRGB), .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB), .HBLK(HBLK), .VBLK(VBLK),
        .HSYN(HSYN), .VSYN(VSYN), .FRAME_STB(FRAME_STB)
    );

    always #5 MCLK = ~MCLK;

    int total = 0;
    int bad   = 0;

    // Reference model state: k = pixel enables since reset; cur_* = offsets governing the frame holding position k.
    int            k;
    int            cur_ha;
    int            cur_va;
    logic          e_hblk, e_vblk, e_hsyn, e_vsyn, e_stb;
    logic [RW-1:0] e_rgb;

    function automatic int pmod(input int a, input int m);
        int r;
        r = a % m;
        return (r < 0) ? r + m : r;
    endfunction

    // True when pos falls in the len-long window starting at start, all modulo tot.
    function automatic bit in_win(input int pos, input int start, input int len, input int tot);
        return pmod(pos - pmod(start, tot), tot) < len;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        k      = 0;
        cur_ha = 0;
        cur_va = 0;
        e_hblk = 1'b1;
        e_vblk = 1'b1;
        e_hsyn = 1'b1;
        e_vsyn = 1'b1;
        e_stb  = 1'b0;
        e_rgb  = '0;
    endtask

    task automatic model_ce();
        int p, ph, pv, ha_p;
        p    = k;
        ph   = p % HT;
        pv   = (p / HT) % VT;
        ha_p = cur_ha;
        e_stb = (p % FT == FT - 1);
        if (e_stb) begin
            cur_ha = int'($signed(H_ADJ));
            cur_va = int'($signed(V_ADJ));
        end
        k++;
        e_hblk = !(ph >= HAS && ph < HAS + HA);
        e_vblk = !(pv >= VAS && pv < VAS + VA);
        e_rgb  = (e_hblk || e_vblk) ? '0 : iRGB;
        e_hsyn = !in_win(ph, HSS + ha_p, HSL, HT);
        e_vsyn = (k < HT) ? 1'b1 : !in_win((k / HT) % VT, VSS + cur_va, VSL, VT);
    endtask

    task automatic check_all();
        chk("hpos", 32'(HPOS), pmod(k % HT - HAS, 1 << CW));
        chk("vpos", 32'(VPOS), pmod((k / HT) % VT - VAS, 1 << CW));
        chk("hblk", 32'(HBLK), 32'(e_hblk));
        chk("vblk", 32'(VBLK), 32'(e_vblk));
        chk("hsyn", 32'(HSYN), 32'(e_hsyn));
        chk("vsyn", 32'(VSYN), 32'(e_vsyn));
        chk("orgb", 32'(oRGB), 32'(e_rgb));
        chk("frame_stb", 32'(FRAME_STB), 32'(e_stb));
    endtask

    // Drive one MCLK cycle of inputs, advance the model and compare everything.
    task automatic step(input logic ce, input logic [RW-1:0] rgb, input logic [3:0] ha, input logic [3:0] va);
        CE_PIX = ce;
        iRGB   = rgb;
        H_ADJ  = ha;
        V_ADJ  = va;
        @(posedge MCLK);
        #1;
        if (RESET) begin
            model_reset();
        end else if (ce) begin
            model_ce();
        end else begin
            e_stb = 1'b0;
        end
        check_all();
    endtask

    initial begin
        bit found;

        // Reset state.
        RESET  = 1'b1;
        CE_PIX = 1'b0;
        iRGB   = '0;
        H_ADJ  = '0;
        V_ADJ  = '0;
        model_reset();
        repeat (2) @(posedge MCLK);
        #1;
        check_all();
        RESET = 1'b0;

        // Run into the region where both syncs are low, then reset asynchronously mid-pulse.
        found = 1'b0;
        for (int i = 0; i < FT; i++) begin
            step(1'b1, RW'($urandom), 4'h0, 4'h0);
            if (!e_hsyn && !e_vsyn) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $error("FAIL sync_search observed=none expected=hsyn_and_vsyn_low");
        end
        #3;
        RESET = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (3) step(1'b1, RW'($urandom), 4'h0, 4'h0);
        RESET = 1'b0;

        // Constant white input with constant enable over a full frame.
        for (int i = 0; i < FT; i++) step(1'b1, 12'hFFF, 4'h0, 4'h0);

        // Offsets changed mid-frame take effect only at the next frame; +4/+3 push both windows through 0.
        for (int i = 0; i < 100; i++) step(1'b1, RW'($urandom), 4'h0, 4'h0);
        for (int i = 0; i < 3 * FT; i++) step(1'b1, RW'($urandom), 4'h4, 4'h3);

        // Enable every 4th MCLK with the most negative offsets.
        for (int i = 0; i < 8 * FT; i++) step((i % 4) == 3, RW'($urandom), 4'h8, 4'h8);

        // Random enables with offsets changing every cycle.
        for (int i = 0; i < 6 * FT; i++) step(1'($urandom_range(0, 1)), RW'($urandom), 4'($urandom), 4'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
